// File: rtl/rx_pkt_pkg.sv
// rtl/rx_pkt_pkg.sv - shared types and constants for the receive packet controller
package rx_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_PARITY  = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h7E;

    // A length is acceptable when it is non-zero, within the packet limit and fits the free space.
    function automatic logic len_ok(input logic [7:0] len, input int max_len, input int free);
        return (len != 8'd0) && (int'(len) <= max_len) && (int'(len) <= free);
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - speculative payload FIFO with commit/rewind and first-word-fall-through read
module pkt_fifo #(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [8:0]    i_wr_data,
    input  logic          i_commit,
    input  logic          i_rewind,
    input  logic          i_rd_en,
    output logic [8:0]    o_rd_data,
    output logic          o_rd_valid,
    output logic [AW:0]   o_free
);

    logic [8:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_commit_ptr;
    logic [AW:0] r_rd_ptr;
    logic [8:0]  r_rd_data;

    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [AW:0] w_rd_ptr_nxt;

    assign w_wr_fire    = i_wr_en && !i_rewind;
    assign w_rd_fire    = i_rd_en && o_rd_valid;
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_fire};

    assign o_rd_valid = (r_rd_ptr != r_commit_ptr);
    assign o_rd_data  = o_rd_valid ? r_rd_data : 9'd0;
    assign o_free     = (AW+1)'(DEPTH) - (r_wr_ptr - r_rd_ptr);

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_rd_data    <= '0;
        end else begin
            if (i_rewind) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_commit) begin
                r_commit_ptr <= r_wr_ptr;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            // Refreshed every cycle so the head entry is always current, bypassing a same-cycle write.
            if (w_wr_fire && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[w_rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/rx_packet_ctrl.sv
// rtl/rx_packet_ctrl.sv - frames the UART byte stream into checked packets for the consumer
module rx_packet_ctrl
    import rx_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 32,
    parameter int         TIMEOUT    = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_rx_error,
    output logic [7:0] o_out_data,
    output logic       o_out_last,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_pkt_done,
    output logic       o_pkt_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [7:0]  r_sum;
    logic [TW-1:0] r_tmo;
    logic        r_pkt_done;
    logic        r_pkt_err;
    logic [1:0]  r_err_code;

    logic        w_wr_en;
    logic        w_wr_last;
    logic        w_commit;
    logic        w_drop;
    logic [1:0]  w_drop_code;
    logic        w_tmo_hit;
    logic [8:0]  w_rd_data;
    logic [AW:0] w_free;

    pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_data  ({w_wr_last, i_rx_data}),
        .i_commit   (w_commit),
        .i_rewind   (w_drop),
        .i_rd_en    (i_out_ready),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (o_out_valid),
        .o_free     (w_free)
    );

    assign o_out_data = w_rd_data[7:0];
    assign o_out_last = w_rd_data[8];
    assign o_pkt_done = r_pkt_done;
    assign o_pkt_err  = r_pkt_err;
    assign o_err_code = r_err_code;
    assign o_busy     = (r_state != ST_IDLE);

    assign w_tmo_hit = (r_state != ST_IDLE) && !i_rx_valid && (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_last   = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_drop_code = r_err_code;
        if (w_tmo_hit) begin
            w_drop      = 1'b1;
            w_drop_code = ERR_TIMEOUT;
        end else if (i_rx_valid) begin
            if ((r_state != ST_IDLE) && i_rx_error) begin
                w_drop      = 1'b1;
                w_drop_code = ERR_PARITY;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if ((i_rx_data == SYNC_BYTE) && !i_rx_error) begin
                            w_state_nxt = ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (len_ok(i_rx_data, MAX_LEN, int'(w_free))) begin
                            w_state_nxt = ST_PAYLOAD;
                        end else begin
                            w_drop      = 1'b1;
                            w_drop_code = ERR_LEN;
                        end
                    end
                    ST_PAYLOAD: begin
                        w_wr_en   = 1'b1;
                        w_wr_last = ((r_cnt + 8'd1) == r_len);
                        if (w_wr_last) begin
                            w_state_nxt = ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (8'(r_sum + i_rx_data) == 8'd0) begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_drop      = 1'b1;
                            w_drop_code = ERR_CSUM;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
        if (w_drop) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= ERR_PARITY;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_done <= w_commit;
            r_pkt_err  <= w_drop;
            if (w_drop) begin
                r_err_code <= w_drop_code;
            end
            if ((r_state == ST_LEN) && i_rx_valid) begin
                r_len <= i_rx_data;
                r_sum <= i_rx_data;
                r_cnt <= '0;
            end else if (w_wr_en) begin
                r_cnt <= r_cnt + 8'd1;
                r_sum <= r_sum + i_rx_data;
            end
            // Counts idle cycles only while a packet is open; any received byte restarts it.
            if ((r_state == ST_IDLE) || i_rx_valid) begin
                r_tmo <= '0;
            end else if (!w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb/tb_rx_packet_ctrl.sv - scoreboard bench for rx_packet_ctrl
module tb_rx_packet_ctrl;
    import rx_pkt_pkg::*;

    localparam int MAX_LEN    = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int TIMEOUT    = 1000;
    localparam logic [7:0] SYNC = 8'h7E;
    localparam int EV_DONE    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] o_out_data;
    logic       o_out_last;
    logic       o_out_valid;
    logic       o_pkt_done;
    logic       o_pkt_err;
    logic [1:0] o_err_code;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;
    logic [8:0] exp_data_q[$];
    int         exp_ev_q[$];
    logic [7:0] pl [MAX_LEN];

    always #5 clk = ~clk;

    rx_packet_ctrl #(
        .SYNC_BYTE  (SYNC),
        .MAX_LEN    (MAX_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_rx_error  (rx_error),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_out_valid (o_out_valid),
        .i_out_ready (out_ready),
        .o_pkt_done  (o_pkt_done),
        .o_pkt_err   (o_pkt_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = (ready_mode == 1);
    end

    // Monitor: compares every handshake and status pulse with what the model queued.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (o_out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_extra: got %0h, expected no byte", {o_out_last, o_out_data});
                end else begin
                    check("out_byte", {23'd0, o_out_last, o_out_data}, {23'd0, exp_data_q.pop_front()});
                end
            end
            if (o_pkt_done || o_pkt_err) begin
                if (exp_ev_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pkt_event_extra: got done=%0d err=%0d, expected none", o_pkt_done, o_pkt_err);
                end else begin
                    check("pkt_event", o_pkt_done ? EV_DONE : 32'(o_err_code), exp_ev_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = e;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic gap(input int gmax);
        repeat ($urandom_range(0, gmax)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 good, 1 bad checksum, 2 parity error at byte pidx (1..len payload, len+1 checksum)
    task automatic send_pkt(input int len, input int kind, input int pidx, input int gmax, input bit chk_hidden);
        logic [7:0] sum;
        logic [7:0] csum;
        int free;
        free = FIFO_DEPTH - exp_data_q.size();
        send_byte(SYNC, 1'b0);
        gap(gmax);
        if (len == 0 || len > MAX_LEN || len > free) begin
            exp_ev_q.push_back(int'(ERR_LEN));
            send_byte(8'(len), 1'b0);
            return;
        end
        send_byte(8'(len), 1'b0);
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
            gap(gmax);
            if (kind == 2 && pidx == i + 1) begin
                exp_ev_q.push_back(int'(ERR_PARITY));
                send_byte(pl[i], 1'b1);
                return;
            end
            send_byte(pl[i], 1'b0);
            sum = sum + pl[i];
        end
        csum = 8'(0) - sum;
        gap(gmax);
        if (chk_hidden) check("valid_before_csum", o_out_valid, 0);
        if (kind == 2) begin
            exp_ev_q.push_back(int'(ERR_PARITY));
            send_byte(csum, 1'b1);
        end else if (kind == 1) begin
            exp_ev_q.push_back(int'(ERR_CSUM));
            send_byte(csum + 8'd1, 1'b0);
        end else begin
            for (int i = 0; i < len; i++) exp_data_q.push_back({(i == len - 1), pl[i]});
            exp_ev_q.push_back(EV_DONE);
            send_byte(csum, 1'b0);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'($urandom);
    endtask

    task automatic drain(input string nm);
        int cyc;
        cyc = 0;
        while ((exp_data_q.size() != 0 || exp_ev_q.size() != 0) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(nm, 32'(exp_data_q.size() + exp_ev_q.size()), 0);
    endtask

    initial begin
        int len, kind, pidx, cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {o_out_valid, o_out_last, o_out_data, o_pkt_done, o_pkt_err, o_err_code, o_busy}, 0);
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(3, 0, 0, 0, 1'b1);
        drain("good_pkt_drained");

        send_pkt(3, 1, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_csum_code", o_err_code, ERR_CSUM);
        check("bad_csum_empty", o_out_valid, 0);
        drain("bad_csum_drained");

        send_pkt(3, 2, 2, 0, 1'b0);
        @(posedge clk);
        #1;
        check("parity_code", o_err_code, ERR_PARITY);
        rand_payload();
        send_pkt(5, 0, 0, 1, 1'b0);
        drain("after_parity");

        send_byte(SYNC, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        send_pkt(2, 0, 0, 0, 1'b0);
        drain("idle_noise");

        send_pkt(0, 0, 0, 0, 1'b0);
        send_pkt(MAX_LEN + 1, 0, 0, 0, 1'b0);
        drain("len_range");

        ready_mode = 0;
        @(posedge clk);
        #1;
        rand_payload();
        send_pkt(16, 0, 0, 0, 1'b0);
        rand_payload();
        send_pkt(4, 0, 0, 0, 1'b0);
        send_pkt(16, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("overflow_code", o_err_code, ERR_LEN);
        check("overflow_kept", o_out_valid, 1);
        ready_mode = 1;
        drain("overflow_data_intact");

        exp_ev_q.push_back(int'(ERR_TIMEOUT));
        send_byte(SYNC, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("tmo_not_early", o_pkt_err, 0);
        check("tmo_busy_held", o_busy, 1);
        @(posedge clk);
        #1;
        check("tmo_fires", o_pkt_err, 1);
        check("tmo_code", o_err_code, ERR_TIMEOUT);
        check("tmo_idle", o_busy, 0);
        drain("tmo_drained");

        ready_mode = 2;
        rand_payload();
        send_pkt(5, 0, 0, 0, 1'b0);
        rand_payload();
        send_pkt(7, 0, 0, 0, 1'b0);
        drain("back_to_back");

        for (int p = 0; p < 40; p++) begin
            cyc = 0;
            while (exp_data_q.size() > 16 && cyc < 500) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            rand_payload();
            len  = $urandom_range(1, 8);
            kind = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2);
            pidx = $urandom_range(1, len + 1);
            send_pkt(len, kind, pidx, 2, 1'b0);
        end
        drain("random_stream");

        ready_mode = 0;
        @(posedge clk);
        #1;
        rand_payload();
        send_pkt(3, 0, 0, 0, 1'b0);
        send_pkt(2, 1, 0, 0, 1'b0);
        send_byte(SYNC, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hC3, 1'b0);
        rst_n = 1'b0;
        #2;
        check("rst_mid_payload", {o_out_valid, o_out_last, o_out_data, o_pkt_done, o_pkt_err, o_err_code, o_busy}, 0);
        exp_data_q.delete();
        exp_ev_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_discards", o_out_valid, 0);
        rand_payload();
        send_pkt(4, 0, 0, 0, 1'b0);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Receive-side packet controller sitting between the UART receiver's byte output and the host/consumer logic. It frames the byte stream as packets: sync byte, length, payload, checksum. Payload is buffered speculatively in an internal FIFO, committed to the consumer only when the checksum passes, and rewound on any framing, parity, checksum or timeout error. The consumer sees a ready/valid byte stream with an end-of-packet marker, plus per-packet status pulses.

## Interface
- `SYNC_BYTE`, 8'h7E: start-of-packet marker.
- `MAX_LEN`, 16: maximum payload length in bytes; legal range 1..MAX_LEN.
- `FIFO_DEPTH`, 32: payload FIFO entries; power of two, ≥ MAX_LEN.
- `TIMEOUT`, 1000: inter-byte timeout in clk cycles while mid-packet.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `rx_error` in 1: parity error for the byte in the same cycle as `rx_valid`.
- `out_data` out 8: payload byte to the consumer.
- `out_last` out 1: marks the final byte of a packet.
- `out_valid` out 1: `out_data`/`out_last` are valid.
- `out_ready` in 1: consumer accepts the byte when `out_valid`&&`out_ready`.
- `pkt_done` out 1: one-cycle pulse when a packet is committed.
- `pkt_err` out 1: one-cycle pulse when a packet is dropped.
- `err_code` out 2: cause, held until the next `pkt_err`. Encoding: 00 parity, 01 length/overflow, 10 checksum, 11 timeout.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, LEN, PAYLOAD, CSUM. Only a byte with `rx_valid`=1 advances the FSM.
- **IDLE**
  - Byte == SYNC_BYTE with `rx_error`=0 → LEN.
  - All other bytes are discarded silently, including bytes with `rx_error`=1.
- **LEN**
  - Store the byte as `len`; seed `sum` = byte.
  - `len`==0, `len`>MAX_LEN, or `len` > free FIFO space → drop, code 01.
  - Otherwise → PAYLOAD.
  - Free space = FIFO_DEPTH − (wr_ptr − rd_ptr), evaluated in the LEN cycle.
- **PAYLOAD**
  - Each byte is written to the FIFO at wr_ptr, and `sum` += byte (8-bit wrap).
  - The entry's `last` flag is set when the count reaches `len`.
  - After `len` bytes → CSUM.
- **CSUM**
  - If (`sum` + byte) mod 256 == 0: commit_ptr ← wr_ptr, pulse `pkt_done`, → IDLE.
  - Otherwise: drop, code 10.
- **Any non-IDLE state**
  - A byte with `rx_error`=1 → drop, code 00.
  - `TIMEOUT` cycles without `rx_valid` → drop, code 11. The timeout counter resets on every `rx_valid`.
- **Drop**
  - wr_ptr ← commit_ptr, pulse `pkt_err`, latch `err_code`, → IDLE.
  - The dropped byte is not re-examined as SYNC.
- **Consumer side**
  - `out_valid` = (rd_ptr ≠ commit_ptr). Uncommitted entries are never visible.
  - rd_ptr increments on `out_valid`&&`out_ready`.
- **Pointers**: log2(FIFO_DEPTH)+1 bits, wrap naturally. Full/empty are distinguished by the MSB.
- **Simultaneous events**
  - A read and a write/commit/rewind in the same cycle are all legal and independent.
  - A read never passes commit_ptr.
  - A rewind never moves below rd_ptr, because commit_ptr ≥ rd_ptr always holds.

## Timing
- **Reset values**: FSM=IDLE; all pointers 0; `out_valid`=0, `out_last`=0, `out_data`=0, `pkt_done`=0, `pkt_err`=0, `err_code`=00, `busy`=0; counters 0.
- Reset asserted mid-packet discards both committed and uncommitted data.
- **Commit latency**: the first `out_valid` appears the cycle after the edge that samples the good checksum byte. `pkt_done` is high in that same cycle.
- **Drop**: `pkt_err` and the new `err_code` are visible the cycle after the offending edge.
- **Timeout**: fires on exactly the TIMEOUT-th idle cycle after the last `rx_valid`.
- **Read path**: `out_data`/`out_last` come from registered FIFO read (first-word-fall-through); the next entry is presented the cycle after a handshake.
- Back-to-back `rx_valid` on consecutive cycles must be supported.

## Structure
- **Shared package/include `rx_pkt_pkg`**:
  - FSM state encoding.
  - `err_code` constants: ERR_PARITY, ERR_LEN, ERR_CSUM, ERR_TIMEOUT.
  - Default SYNC_BYTE.
- **Sub-module `pkt_fifo`**:
  - 9-bit wide storage (data + last).
  - wr/commit/rewind/rd pointers.
  - Free-count output.
- **Top level**: FSM, length/sum/timeout counters, status outputs.

## Test plan
- **Good packet**: 7E 03 11 22 33 97.
  - `pkt_done` pulses once.
  - Consumer reads 11, 22, 33 with `out_last` on 33.
  - `out_valid` is 0 before the checksum byte.
- **Bad checksum**: 7E 03 11 22 33 98.
  - `pkt_err`, `err_code`=10.
  - `out_valid` never rises; FIFO is empty afterwards.
- **Parity error mid-payload**: `rx_error`=1 on the 2nd payload byte.
  - Code 00, rewind.
  - The following good packet is delivered intact.
- **Length errors**:
  - Length 00 → code 01.
  - Length MAX_LEN+1 → code 01.
  - With `out_ready`=0 holding 20 committed bytes and FIFO_DEPTH=32, a len=16 packet → code 01, and the 20 committed bytes remain intact.
- **Timeout**: 7E 02 AA, then silence.
  - `pkt_err` with code 11 exactly TIMEOUT cycles after AA.
  - `busy` returns to 0.
- **Concurrency and reset**:
  - Stream two good packets back-to-back while the consumer reads with random `out_ready`: both are delivered in order with correct `out_last`.
  - Assert reset mid-payload: all outputs return to reset values.
